seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 2-bit combinational multiplier.
- Multiplies two WIDTH-bit operands in one of two modes: unsigned, or two's-complement signed.
- Uses a start/busy/done handshake.
- Sits in the datapath where area matters more than single-cycle latency; one operation in flight at a time.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; product is valid
- product  output  2*WIDTH  result; held from done until the next done

Behaviour:
- Reset (asynchronous, active-high, any state):
  - state = IDLE, busy = 0, done = 0, product = 0.
  - Internal accumulator, operand registers, counter and sign flag cleared.
  - Any operation in flight is discarded, with no done pulse.
- All outputs are registered.
- States: IDLE, CALC, FIX.
- IDLE:
  - done is held low except for the pulse defined under FIX.
  - Edge with start = 1 (edge E0): latch the operand magnitudes and sign flag, clear the accumulator, set count = 0, busy <= 1, go to CALC.
  - Operand magnitudes:
    - Unsigned mode: a and b as given.
    - Signed mode: absolute value of each operand, held as an unsigned WIDTH-bit value. The most negative value maps to 2^(WIDTH-1), which is representable.
  - Sign flag = a[MSB] XOR b[MSB] when signed_mode = 1, else 0.
  - start = 0: remain in IDLE.
- CALC: one step per edge (E1..E_WIDTH).
  - If multiplier LSB = 1, add the shifted multiplicand to the accumulator (2*WIDTH-bit add, no overflow possible).
  - Shift the multiplicand left 1 and the multiplier right 1; count++.
  - At the edge where count reaches WIDTH-1 → go to FIX.
- FIX: single edge, E_(WIDTH+1).
  - product <= sign flag ? two's-complement negation of the accumulator : accumulator.
  - done <= 1 for exactly one cycle, busy <= 0, go to IDLE.
- Latency: done is high in the cycle after edge E_(WIDTH+1), i.e. WIDTH+1 cycles after the accepting edge. For WIDTH = 4 that is 5 cycles.
- busy is high for exactly WIDTH+1 cycles per operation.
- start while busy = 1: ignored, with no queueing. Operands and signed_mode changing during busy have no effect.
- Back-to-back operation: start may be asserted in the same cycle done is high (state is already IDLE). It is accepted, giving a new busy period with no idle gap. product keeps the previous result until the next done.
- Signed range: every WIDTH-bit signed × signed product fits in 2*WIDTH signed bits. Example: (-2^(WIDTH-1))² = 2^(2*WIDTH-2) is positive and representable.
- Multiply by zero: normal latency; product = 0; done still pulses.
- done never coincides with busy = 1.

Test Plan:
- Unsigned small, WIDTH=4:
  - Stimulus: a=4'b0010, b=4'b0011, signed_mode=0, start for 1 cycle.
  - Response: busy high for 5 cycles, then done pulse for 1 cycle with product=8'h06; product holds 8'h06 afterwards.
- Unsigned max and zero:
  - Stimulus 1: a=4'hF, b=4'hF, signed_mode=0 → response: product=8'hE1 (225).
  - Stimulus 2: a=4'h0, b=4'h9 → response: product=8'h00 with a normal done pulse.
- Signed corners, signed_mode=1:
  - a=4'h8 (-8), b=4'h8 (-8) → product=8'h40 (+64).
  - a=4'hD (-3), b=4'h5 → product=8'hF1 (-15).
  - a=4'h7, b=4'h8 → product=8'hC8 (-56).
- Start during busy:
  - Stimulus: issue 3×5 unsigned; at cycle 2 of busy, drive start=1 with a=4'hF, b=4'hF.
  - Response: only one done pulse, product=8'h0F; no second operation begins.
- Back-to-back:
  - Stimulus: assert start with a=2, b=3 in the cycle done is high for the previous op.
  - Response: busy rises on the next cycle; next done arrives 5 cycles later with product=8'h06; no idle gap.
- Reset mid-operation:
  - Stimulus: pulse rst asynchronously (between clock edges) in cycle 3 of a busy period.
  - Response: busy=0, done=0 and product=8'h00 immediately, without waiting for a clock edge; no done pulse follows; the next start then completes normally.
- Parameter sweep:
  - Stimulus: repeat random signed and unsigned vectors at WIDTH=2 and WIDTH=8 against a behavioural a*b model.
  - Response: all results match; busy length = WIDTH+1 cycles.

Source files
------------

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, unsigned or two's-complement signed.
// Signed operands are reduced to magnitudes up front, multiplied as unsigned,
// and the sign is applied once in FIX, so the CALC loop never deals with sign.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Counter must hold 0..WIDTH (it increments once more on the last step).
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [CW-1:0]        count_reg;
    logic                 neg_reg;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   add_term, acc_sum, fixed_val;

    // Magnitudes: the most negative value negates to itself, which read as
    // unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    assign a_mag     = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign add_term  = mplier_reg[0] ? mcand_reg : '0;
    assign acc_sum   = acc_reg + add_term;
    assign fixed_val = neg_reg ? -acc_reg : acc_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: accept in IDLE, WIDTH steps in CALC, one FIX edge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count_reg == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        busy_next    = (state_next != IDLE);
        done_next    = (state_reg == FIX);
        product_next = (state_reg == FIX) ? fixed_val : product_reg;
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            product_reg <= product_next;
        end
    end

    // Datapath: load operands on accept, one shift-add step per CALC edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            neg_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_reg <= b_mag;
                        acc_reg    <= '0;
                        count_reg  <= '0;
                        neg_reg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                CALC: begin
                    acc_reg    <= acc_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: directed table and corner sequences on WIDTH=4, plus a
// random sweep that runs WIDTH=2, 4 and 8 side by side against plain a*b.
module tb_seq_mult;

    logic clk = 1'b0;
    logic rst;
    logic sm;
    logic start4, start_sw;
    logic [1:0] a2, b2;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic busy2, busy4, busy8, done2, done4, done8;
    logic [3:0]  product2;
    logic [7:0]  product4;
    logic [15:0] product8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .start(start_sw), .signed_mode(sm),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2));
    seq_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .signed_mode(sm),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4));
    seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start_sw), .signed_mode(sm),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        bit         s;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: interpret operands as integers of width w and multiply.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input bit s);
        longint xv, yv, pv;
        longint unsigned m;
        xv = longint'(x) & ((longint'(1) << w) - 1);
        yv = longint'(y) & ((longint'(1) << w) - 1);
        if (s && xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
        if (s && yv >= (longint'(1) << (w - 1))) yv = yv - (longint'(1) << w);
        pv = xv * yv;
        m  = (longint'(1) << (2 * w)) - 1;
        return 64'(pv) & m;
    endfunction

    // One WIDTH=4 operation; operand inputs are scrambled while busy.
    task automatic op4(input logic [3:0] x, input logic [3:0] y, input bit s,
                       output logic [7:0] p, output int bcnt, output bit seen);
        tick();
        start4 = 1'b1; a4 = x; b4 = y; sm = s;
        tick();
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm = 1'($urandom);
        bcnt = 0; seen = 1'b0; p = '0;
        for (int i = 0; i < 20; i++) begin
            if (done4) begin
                seen = 1'b1;
                p = product4;
                break;
            end
            if (busy4) bcnt++;
            tick();
        end
    endtask

    initial begin
        logic [7:0] p;
        int bcnt, ndone;
        bit seen;

        tbl[0] = '{4'h2, 4'h3, 1'b0, 8'h06};
        tbl[1] = '{4'hF, 4'hF, 1'b0, 8'hE1};
        tbl[2] = '{4'h0, 4'h9, 1'b0, 8'h00};
        tbl[3] = '{4'h8, 4'h8, 1'b1, 8'h40};
        tbl[4] = '{4'hD, 4'h5, 1'b1, 8'hF1};
        tbl[5] = '{4'h7, 4'h8, 1'b1, 8'hC8};
        tbl[6] = '{4'h3, 4'h5, 1'b0, 8'h0F};
        tbl[7] = '{4'hF, 4'hF, 1'b1, 8'h01};

        rst = 1'b1; sm = 1'b0; start4 = 1'b0; start_sw = 1'b0;
        a2 = '0; b2 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        tick();
        tick();
        check("reset_busy", 64'(busy4), 64'd0);
        check("reset_done", 64'(done4), 64'd0);
        check("reset_product", 64'(product4), 64'd0);
        rst = 1'b0;

        // Directed table on WIDTH=4.
        for (int i = 0; i < 8; i++) begin
            op4(tbl[i].a, tbl[i].b, tbl[i].s, p, bcnt, seen);
            $display("vec %0d: a=%h b=%h s=%0d -> product=%h busy=%0d", i,
                     tbl[i].a, tbl[i].b, tbl[i].s, p, bcnt);
            check("tbl_done_seen", 64'(seen), 64'd1);
            check("tbl_product", 64'(p), 64'(tbl[i].exp));
            check("tbl_busy_len", 64'(bcnt), 64'd5);
            tick();
            check("tbl_done_pulse", 64'(done4), 64'd0);
            check("tbl_product_hold", 64'(product4), 64'(tbl[i].exp));
        end

        // Start while busy is ignored.
        tick();
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd5; sm = 1'b0;
        tick();
        start4 = 1'b0;
        bcnt = busy4 ? 1 : 0;
        tick();
        if (busy4) bcnt++;
        start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        tick();
        start4 = 1'b0;
        ndone = 0; p = '0;
        for (int i = 0; i < 15; i++) begin
            if (done4) begin ndone++; p = product4; end
            if (busy4) bcnt++;
            tick();
        end
        $display("busy-start: dones=%0d product=%h busy=%0d", ndone, p, bcnt);
        check("busy_start_dones", 64'(ndone), 64'd1);
        check("busy_start_product", 64'(p), 64'h0F);
        check("busy_start_busy_len", 64'(bcnt), 64'd5);

        // Back-to-back: new start in the done cycle.
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd5;
        tick();
        start4 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done4) begin seen = 1'b1; break; end
            tick();
        end
        check("b2b_first_done", 64'(seen), 64'd1);
        check("b2b_first_product", 64'(product4), 64'h19);
        start4 = 1'b1; a4 = 4'd2; b4 = 4'd3;
        tick();
        start4 = 1'b0;
        check("b2b_busy_rise", 64'(busy4), 64'd1);
        check("b2b_done_low", 64'(done4), 64'd0);
        check("b2b_product_hold", 64'(product4), 64'h19);
        bcnt = 1; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done4) begin seen = 1'b1; break; end
            if (busy4) bcnt++;
        end
        $display("back-to-back: product=%h busy=%0d", product4, bcnt);
        check("b2b_second_done", 64'(seen), 64'd1);
        check("b2b_second_product", 64'(product4), 64'h06);
        check("b2b_busy_len", 64'(bcnt), 64'd5);

        // Asynchronous reset in the third busy cycle.
        tick();
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy4), 64'd0);
        check("arst_done", 64'(done4), 64'd0);
        check("arst_product", 64'(product4), 64'd0);
        #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done4 || busy4) ndone++;
        end
        check("arst_no_activity", 64'(ndone), 64'd0);
        op4(4'd2, 4'd3, 1'b0, p, bcnt, seen);
        $display("after reset: product=%h busy=%0d", p, bcnt);
        check("arst_next_done", 64'(seen), 64'd1);
        check("arst_next_product", 64'(p), 64'h06);

        // Random sweep across widths 2, 4, 8 running concurrently.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] xa[3], xb[3];
            logic [63:0] pr[3];
            int bc[3];
            bit got[3];
            int overlap;
            bit s;
            s = 1'($urandom);
            for (int k = 0; k < 3; k++) begin
                xa[k] = $urandom; xb[k] = $urandom;
                bc[k] = 0; got[k] = 1'b0; pr[k] = '0;
            end
            // Force the most negative operand now and then.
            if (n % 8 == 0) begin
                xa[0] = 32'h2; xa[1] = 32'h8; xa[2] = 32'h80;
                xb[0] = 32'h2; xb[1] = 32'h8; xb[2] = 32'h80;
            end
            overlap = 0;
            tick();
            sm = s; start4 = 1'b1; start_sw = 1'b1;
            a2 = xa[0][1:0]; b2 = xb[0][1:0];
            a4 = xa[1][3:0]; b4 = xb[1][3:0];
            a8 = xa[2][7:0]; b8 = xb[2][7:0];
            tick();
            start4 = 1'b0; start_sw = 1'b0; sm = 1'($urandom);
            a2 = 2'($urandom); a4 = 4'($urandom); a8 = 8'($urandom);
            for (int c = 0; c < 30; c++) begin
                if (busy2) bc[0]++;
                if (busy4) bc[1]++;
                if (busy8) bc[2]++;
                if ((busy2 && done2) || (busy4 && done4) || (busy8 && done8)) overlap++;
                if (done2 && !got[0]) begin got[0] = 1'b1; pr[0] = 64'(product2); end
                if (done4 && !got[1]) begin got[1] = 1'b1; pr[1] = 64'(product4); end
                if (done8 && !got[2]) begin got[2] = 1'b1; pr[2] = 64'(product8); end
                if (got[0] && got[1] && got[2]) break;
                tick();
            end
            $display("sweep %0d s=%0d: w2 %h*%h=%h w4 %h*%h=%h w8 %h*%h=%h", n, s,
                     xa[0][1:0], xb[0][1:0], pr[0], xa[1][3:0], xb[1][3:0], pr[1],
                     xa[2][7:0], xb[2][7:0], pr[2]);
            check("sweep_overlap", 64'(overlap), 64'd0);
            for (int k = 0; k < 3; k++) begin
                int w;
                w = 2 << k;
                check("sweep_done_seen", 64'(got[k]), 64'd1);
                check("sweep_product", pr[k], ref_mul(w, xa[k], xb[k], s));
                check("sweep_busy_len", 64'(bc[k]), 64'(w + 1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
